// File: rtl/icache_sa.sv
// Set-associative read-only instruction cache: multi-word lines, burst refill, round-robin victim.
// Define ICACHE_FLUSH_EN to add the flush port (invalidate all lines from IDLE).
module icache_sa #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  output logic [DATA_W-1:0] cpu_resp_data,
  output logic              cpu_resp_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic              mem_resp_valid
`ifdef ICACHE_FLUSH_EN
  ,input logic              flush
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESPOND} state_e;

  state_e                           state_q, state_d;
  logic [ADDR_W-1:2]                addr_q, addr_d;
  logic [WAY_W-1:0]                 victim_q, victim_d;
  logic [OFF_W-1:0]                 beat_q, beat_d;
  logic [DATA_W-1:0]                fill_word_q, fill_word_d;
  logic [DATA_W-1:0]                resp_data_q, resp_data_d;
  logic                             resp_valid_q, resp_valid_d;
  logic                             ready_q, ready_d;
  logic                             mreq_valid_q, mreq_valid_d;
  logic [ADDR_W-1:0]                mreq_addr_q, mreq_addr_d;
  logic [WAYS-1:0][SETS-1:0]        valid_q, valid_d;
  logic [SETS-1:0][WAY_W-1:0]       rr_q, rr_d;

  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0] data_mem [WAYS][SETS][LINE_WORDS];

  logic              data_we, tag_we;
  logic              flush_s;
  logic              unused_addr_bits;

`ifdef ICACHE_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif
  assign unused_addr_bits = ^cpu_req_addr[1:0];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  assign req_tag = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx = addr_q[OFF_W+2 +: IDX_W];
  assign req_off = addr_q[2 +: OFF_W];

  logic [WAYS-1:0]   hit_vec;
  logic [DATA_W-1:0] hit_word;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;

  always_comb begin
    hit_vec   = '0;
    hit_word  = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag);
      if (hit_vec[w]) hit_word = hit_word | data_mem[w][req_idx][req_off];
    end
    // Descending scan leaves the lowest-numbered invalid way selected.
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    victim_d     = victim_q;
    beat_d       = beat_q;
    fill_word_d  = fill_word_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    mreq_valid_d = mreq_valid_q;
    mreq_addr_d  = mreq_addr_q;
    valid_d      = valid_q;
    rr_d         = rr_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_s) begin
          valid_d = '0;
          rr_d    = '0;
        end else if (cpu_req_valid && cpu_req_ready) begin
          addr_d  = cpu_req_addr[ADDR_W-1:2];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (|hit_vec) begin
          resp_data_d  = hit_word;
          resp_valid_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          victim_d     = inv_found ? inv_way : rr_q[req_idx];
          mreq_valid_d = 1'b1;
          mreq_addr_d  = {addr_q[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
          beat_d       = '0;
          state_d      = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (mem_req_ready) begin
          mreq_valid_d = 1'b0;
          state_d      = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_resp_valid) begin
          data_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == req_off) fill_word_d = mem_resp_data;
          if (&beat_q) begin
            tag_we                     = 1'b1;
            valid_d[victim_q][req_idx] = 1'b1;
            if (WAYS > 1 && victim_q == rr_q[req_idx])
              rr_d[req_idx] = rr_q[req_idx] + 1'b1;
            // Requested word may be this very beat, not yet captured.
            resp_data_d  = (beat_q == req_off) ? mem_resp_data : fill_word_q;
            resp_valid_d = 1'b1;
            state_d      = S_RESPOND;
          end
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      victim_q     <= '0;
      beat_q       <= '0;
      fill_word_q  <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      mreq_valid_q <= 1'b0;
      mreq_addr_q  <= '0;
      valid_q      <= '0;
      rr_q         <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      victim_q     <= victim_d;
      beat_q       <= beat_d;
      fill_word_q  <= fill_word_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      ready_q      <= ready_d;
      mreq_valid_q <= mreq_valid_d;
      mreq_addr_q  <= mreq_addr_d;
      valid_q      <= valid_d;
      rr_q         <= rr_d;
    end
  end

  // Line storage needs no reset: a line is only visible once its valid bit is set.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[victim_q][req_idx][beat_q] <= mem_resp_data;
    if (tag_we)  tag_mem[victim_q][req_idx]          <= req_tag;
  end

  assign cpu_req_ready  = ready_q & ~flush_s;
  assign cpu_resp_data  = resp_data_q;
  assign cpu_resp_valid = resp_valid_q;
  assign mem_req_addr   = mreq_addr_q;
  assign mem_req_valid  = mreq_valid_q;

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: directed plan steps, then random fetches against a line-level model.
module tb_icache_sa;
  localparam int SETS = 16;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_req_addr;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic [31:0] cpu_resp_data;
  logic        cpu_resp_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_resp_data;
  logic        mem_resp_valid;
`ifdef ICACHE_FLUSH_EN
  logic        flush;
`endif

  int checks = 0;
  int errors = 0;

  // Model: which line address each way of each set holds, plus the round-robin pointer.
  bit          mv    [SETS][WAYS];
  logic [31:0] mline [SETS][WAYS];
  int          mrr   [SETS];

  icache_sa dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_addr(cpu_req_addr), .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_resp_data(cpu_resp_data), .cpu_resp_valid(cpu_resp_valid),
    .mem_req_addr(mem_req_addr), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_resp_data(mem_resp_data), .mem_resp_valid(mem_resp_valid)
`ifdef ICACHE_FLUSH_EN
    , .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] line, input int k);
    if (line == 32'h100) return 32'hA0 + 32'(k);
    return (line | 32'(k * 4)) ^ 32'h9E37_79B9;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 4) & 32'(SETS - 1));
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int s = set_of(a);
    for (int w = 0; w < WAYS; w++)
      if (mv[s][w] && mline[s][w] == (a & ~32'hF)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_fill(input logic [31:0] a);
    int s = set_of(a);
    int v = -1;
    for (int w = 0; w < WAYS; w++) if (!mv[s][w] && v < 0) v = w;
    if (v < 0) v = mrr[s];
    if (v == mrr[s]) mrr[s] = (mrr[s] + 1) % WAYS;
    mv[s][v]    = 1'b1;
    mline[s][v] = a & ~32'hF;
  endtask

  task automatic m_clear();
    for (int s = 0; s < SETS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  32'(cpu_req_ready), 0);
    chk({tag, "_rvalid"}, 32'(cpu_resp_valid), 0);
    chk({tag, "_rdata"},  cpu_resp_data, 0);
    chk({tag, "_mvalid"}, 32'(mem_req_valid), 0);
    chk({tag, "_maddr"},  mem_req_addr, 0);
  endtask

  // One fetch, driven and observed at negedges. abort_at >= 0 asserts reset before that beat.
  task automatic fetch(input logic [31:0] a, input int rdy_dly, input int gap, input int abort_at,
                       output logic was_hit, output logic [31:0] data, output logic [31:0] maddr);
    logic [31:0] line = a & ~32'hF;
    logic [31:0] exp  = memw(line, int'((a >> 2) & 3));
    bit          eh   = m_hit(a);
    int          n    = 0;
    was_hit = 1'b0; data = '0; maddr = '0;
    while (!cpu_req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready", 32'(cpu_req_ready), 1);
    cpu_req_addr = a; cpu_req_valid = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b0; cpu_req_addr = $urandom;
    chk("lookup_quiet", 32'({cpu_resp_valid, mem_req_valid}), 0);
    @(negedge clk);
    chk("hit_or_miss", 32'(mem_req_valid), 32'(!eh));
    if (!mem_req_valid) begin
      was_hit = 1'b1; data = cpu_resp_data;
      chk("hit_rvalid", 32'(cpu_resp_valid), 1);
      chk("hit_data", cpu_resp_data, exp);
      chk("hit_ready", 32'(cpu_req_ready), 1);
      return;
    end
    maddr = mem_req_addr;
    chk("miss_maddr", mem_req_addr, line);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      chk("mreq_hold_addr", mem_req_addr, line);
      chk("mreq_hold_vld", 32'(mem_req_valid), 1);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("mreq_drop", 32'(mem_req_valid), 0);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(gap, 0)) @(negedge clk);
      if (k == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("abort");
        rst_n = 1'b1;
        m_clear();
        return;
      end
      mem_resp_valid = 1'b1; mem_resp_data = memw(line, k);
      @(negedge clk);
      mem_resp_valid = 1'b0; mem_resp_data = $urandom;
    end
    data = cpu_resp_data;
    chk("miss_rvalid", 32'(cpu_resp_valid), 1);
    chk("miss_data", cpu_resp_data, exp);
    chk("miss_ready_lo", 32'(cpu_req_ready), 0);
    @(negedge clk);
    chk("miss_rvalid_pulse", 32'(cpu_resp_valid), 0);
    chk("miss_ready_hi", 32'(cpu_req_ready), 1);
    if (!eh) m_fill(a);
  endtask

  initial begin
    logic        h;
    logic [31:0] d, ma, a;
    rst_n = 1'b0; cpu_req_addr = '0; cpu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_data = '0; mem_resp_valid = 1'b0;
`ifdef ICACHE_FLUSH_EN
    flush = 1'b0;
`endif
    m_clear();
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(cpu_req_ready), 1);

    // Cold miss and hit after fill
    fetch(32'h104, 0, 0, -1, h, d, ma);
    chk("cold_hit", 32'(h), 0); chk("cold_maddr", ma, 32'h100); chk("cold_data", d, 32'hA1);
    fetch(32'h10C, 0, 0, -1, h, d, ma);
    chk("warm_hit", 32'(h), 1); chk("warm_data", d, 32'hA3);

    // Stray refill beats in IDLE are ignored
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      chk("stray_rvalid", 32'(cpu_resp_valid), 0);
      chk("stray_mvalid", 32'(mem_req_valid), 0);
    end
    mem_resp_valid = 1'b0;
    fetch(32'h108, 0, 0, -1, h, d, ma);
    chk("stray_then_hit", d, 32'hA2);

    // Handshake stress plus round-robin replacement in set 0
    fetch(32'h204, 5, 3, -1, h, d, ma);
    chk("stress_maddr", ma, 32'h200);
    fetch(32'h300, 1, 1, -1, h, d, ma);
    chk("fill_300_miss", 32'(h), 0);
    fetch(32'h208, 0, 0, -1, h, d, ma);
    chk("refetch_200_hit", 32'(h), 1);
    fetch(32'h100, 0, 0, -1, h, d, ma);
    chk("refetch_100_miss", 32'(h), 0);
    fetch(32'h30C, 0, 0, -1, h, d, ma);
    chk("refetch_300_hit", 32'(h), 1);

    // Reset in the middle of a refill
    fetch(32'h404, 0, 1, 2, h, d, ma);
    fetch(32'h404, 0, 0, -1, h, d, ma);
    chk("after_abort_miss", 32'(h), 0);

`ifdef ICACHE_FLUSH_EN
    fetch(32'h100, 0, 0, -1, h, d, ma);
    flush = 1'b1; cpu_req_valid = 1'b1; cpu_req_addr = 32'h100;
    #1 chk("flush_ready_lo", 32'(cpu_req_ready), 0);
    @(negedge clk);
    flush = 1'b0; cpu_req_valid = 1'b0;
    m_clear();
    chk("flush_no_handshake", 32'(cpu_req_ready), 1);
    fetch(32'h104, 0, 0, -1, h, d, ma);
    chk("flush_miss", 32'(h), 0); chk("flush_maddr", ma, 32'h100);
`endif

    // Random fetches over a small address pool to mix hits, conflicts and evictions
    for (int i = 0; i < 80; i++) begin
      a = {22'($urandom_range(3, 0)), 4'($urandom_range(2, 0)), 4'($urandom), 2'($urandom)};
      fetch(a, int'($urandom_range(3, 0)), 2, -1, h, d, ma);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative, read-only instruction cache with multi-word lines, burst refill and round-robin replacement. It sits between the fetch stage and instruction memory. It extends the single-word direct-mapped cache with configurable sets, ways and line size. Being read-only, it has no dirty state and no write-back path.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, instruction word width (fixed 32; byte offset is 2 bits)
- SETS, 16, number of sets (power of two, ≥2)
- WAYS, 2, associativity (power of two, 1..8)
- LINE_WORDS, 4, words per line (power of two, ≥2)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  one clock; reset is synchronous and active-low
- cpu_req_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- cpu_req_valid  in  1  fetch request
- cpu_req_ready  out  1  cache can accept a request
- cpu_resp_data  out  DATA_W  fetched word
- cpu_resp_valid  out  1  one-cycle pulse, cpu_resp_data valid
- mem_req_addr  out  ADDR_W  line-aligned refill address
- mem_req_valid  out  1  refill request
- mem_req_ready  in  1  memory accepts refill request
- mem_resp_data  in  DATA_W  refill beat
- mem_resp_valid  in  1  refill beat valid
- flush  in  1  invalidate all lines (only with ICACHE_FLUSH_EN)

## Operation
- Address split: word offset = addr[OFF+1:2], OFF=log2(LINE_WORDS). Index = next log2(SETS) bits. Tag = remaining upper bits.
- Per way/set state: valid bit, tag, LINE_WORDS data words. Per set: round-robin victim pointer, log2(WAYS) bits.
- States: IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid & cpu_req_ready: latch address; go to LOOKUP.
- LOOKUP:
  - Compare the latched tag against all ways of the set.
  - Hit: register the word into cpu_resp_data; pulse cpu_resp_valid next cycle; go to IDLE.
  - Miss: choose the victim.
    - If any way is invalid, take the lowest-numbered invalid way.
    - Otherwise take the way at the set's round-robin pointer.
  - Go to MISS_REQ.
- MISS_REQ:
  - Drive mem_req_valid=1 with mem_req_addr = latched address with offset and byte bits zeroed.
  - Hold both signals stable until mem_req_ready. Then drop mem_req_valid and go to REFILL.
- REFILL:
  - Accept exactly LINE_WORDS beats on mem_resp_valid, in ascending offset order, with any gaps.
  - Write each beat into the victim way.
  - On the last beat:
    - Set valid and write the tag.
    - If the victim was the round-robin way, advance the pointer (mod WAYS).
    - Go to RESPOND.
- RESPOND: pulse cpu_resp_valid with the requested word; go to IDLE.
- Ignored inputs:
  - mem_resp_valid outside REFILL.
  - cpu_req_valid while cpu_req_ready=0.
- Hits never change the round-robin pointer.

## Timing
- Reset values (rst_n=0 at an edge):
  - state=IDLE; all valid bits 0; all pointers 0.
  - cpu_req_ready=0; cpu_resp_valid=0; cpu_resp_data=0; mem_req_valid=0; mem_req_addr=0.
- cpu_req_ready is registered. It is 1 in the first cycle after rst_n rises.
- Hit latency: handshake at edge N; cpu_resp_valid high in cycle N+2; cpu_req_ready high again in cycle N+2. Throughput is one hit per 2 cycles.
- Miss latency: handshake at edge N; mem_req_valid high from cycle N+2. After the last beat at edge M, cpu_resp_valid is high in cycle M+1 and cpu_req_ready in cycle M+2.
- Reset mid-refill aborts the refill. The partially written line stays invalid. The memory side is reset by the same rst_n.
- WAYS=1 degenerates to direct-mapped; the pointer is unused.

## Configuration
- ICACHE_FLUSH_EN defined:
  - The flush port exists. flush is sampled only in IDLE and has priority over a same-cycle cpu_req_valid (no handshake that cycle).
  - A sampled flush clears all valid bits and pointers on that edge.
  - cpu_req_ready = 0 in any cycle flush=1.
  - flush during a miss is ignored until return to IDLE, which requires the requester to hold it.
- ICACHE_FLUSH_EN undefined: no flush port; valid bits are cleared only by reset.

## Test plan
Default parameters.
- Cold miss:
  - Stimulus: fetch 0x0000_0104; memory returns 0xA0,0xA1,0xA2,0xA3.
  - Required response: mem_req_addr=0x0000_0100; cpu_resp_data=0xA1.
- Hit after fill:
  - Stimulus: fetch 0x0000_010C.
  - Required response: cpu_resp_data=0xA3 two cycles after the handshake; no mem_req_valid.
- Replacement:
  - Stimulus: fill 0x100, 0x200, 0x300 (all set 0).
  - Required response: 0x300 evicts way 0 (0x100). A re-fetch of 0x200 hits; a re-fetch of 0x100 misses and evicts way 1.
- Handshake stress:
  - Stimulus: mem_req_ready delayed 5 cycles; idle gaps between refill beats.
  - Required response: mem_req_addr stays stable; correct word returned; stray mem_resp_valid in IDLE ignored.
- Reset mid-refill:
  - Stimulus: rst_n=0 after 2 beats.
  - Required response: all outputs at reset values; a re-fetch of the same address misses.
- Flush (ICACHE_FLUSH_EN):
  - Stimulus: fill 0x100; pulse flush in IDLE; fetch 0x104.
  - Required response: miss with mem_req_addr=0x100.
